// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: NOP encoding,
// register width and the entry format carried through the prefetch FIFO.
package inst_defs;

   // addi x0, x0, 0
   localparam logic [31:0] NOP = 32'h0000_0013;

   // Width of PC / address registers
   localparam int REG_RANGE = 32;

   // One prefetched instruction together with its PC and fault flag
   typedef struct packed {
      logic [31:0]          instr;
      logic [REG_RANGE-1:0] pc;
      logic                 fault;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries. Clear wins over push and pop; a pop
// on an empty FIFO is ignored, and a push into a full FIFO is accepted
// only when a pop frees a slot on the same edge.
module fetch_fifo
   import inst_defs::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  fetch_entry_t               din,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   fetch_entry_t   store [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [LW-1:0]  count;
   logic           do_pop;
   logic           do_push;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + LW'(1);
         else if (do_pop && !do_push) count <= count - LW'(1);
      end
   end

   // Entry storage; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (do_push && !clear) store[wr_ptr] <= din;
   end

   assign head  = store[rd_ptr];
   assign level = count;
   assign full  = (count == LW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// IF stage: fetch PC, word-addressed instruction RAM with a load port, and
// a prefetch FIFO presenting {instr, pc, fault} to ID.
//
// Handshake: an entry moves to ID on a rising edge where out_valid and
// out_ready are both high. While out_valid=1 and out_ready=0 the head
// (out_instr/out_pc/out_fault) holds steady; out_valid never drops without
// a transfer except on redirect or reset, which flush the queue.
module instr_fetch_queue
   import inst_defs::*;
#(
   parameter int          WIDTH    = 32,
   parameter int          SIZE     = 256,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   localparam int         LOGSIZE  = $clog2(SIZE)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_en,
   input  logic [LOGSIZE+1:0]         wr_addr,
   input  logic [WIDTH-1:0]           instr_in,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_instr,
   output logic [31:0]                out_pc,
   output logic                       out_fault,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   logic [WIDTH-1:0]     mem [SIZE];
   logic [REG_RANGE-1:0] pc;
   logic                 pop;
   logic                 issue;
   logic                 fault;
   logic                 full;
   logic                 empty;
   logic [WIDTH-1:0]     rd_word;
   fetch_entry_t         new_entry;
   fetch_entry_t         head;
   logic                 unused_addr_bits;

   // Byte offset of the load address is meaningless for word writes
   assign unused_addr_bits = ^wr_addr[1:0];

   assign pop   = out_valid & out_ready;
   // Redirect suppresses issue; otherwise issue whenever a slot is (or becomes) free
   assign issue = ~redirect & (~full | pop);
   assign fault = (pc[1:0] != 2'b00) | (pc[REG_RANGE-1:LOGSIZE+2] != '0);

   // The RAM read feeds the FIFO write directly, so the FIFO entry is the
   // read register; a same-edge load-port write is seen only by later fetches
   assign rd_word = mem[pc[LOGSIZE+1:2]];

   // Assemble the entry pushed on issue; faulting fetches carry a NOP
   always_comb begin
      new_entry       = '0;
      new_entry.instr = fault ? NOP : rd_word;
      new_entry.pc    = pc;
      new_entry.fault = fault;
   end

   // Fetch PC: redirect has priority, otherwise advance by one word per issue
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      pc <= RESET_PC;
      else if (redirect) pc <= redirect_pc;
      else if (issue)    pc <= pc + 32'd4;
   end

   // Load port, independent of fetch
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr[LOGSIZE+1:2]] <= instr_in;
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (issue),
      .pop     (pop),
      .clear   (redirect),
      .din     (new_entry),
      .head    (head),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   assign out_valid = ~empty;
   assign out_instr = out_valid ? head.instr : NOP;
   assign out_pc    = out_valid ? head.pc    : 32'd0;
   assign out_fault = out_valid & head.fault;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_instr_fetch_queue;

   localparam int SIZE  = 256;
   localparam int DEPTH = 4;
   localparam logic [31:0] NOP_W   = 32'h0000_0013;
   localparam logic [31:0] RST_PC  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [31:0] instr_in;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_fault;
   logic [2:0]  level;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] mem_m [SIZE];
   logic [31:0] m_pc;
   logic [31:0] q_instr[$];
   logic [31:0] q_pc[$];
   logic        q_fault[$];

   instr_fetch_queue #(
      .WIDTH(32), .SIZE(SIZE), .DEPTH(DEPTH), .RESET_PC(RST_PC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .instr_in(instr_in), .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_fault(out_fault), .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q_instr.delete();
      q_pc.delete();
      q_fault.delete();
   endtask

   task automatic check_outputs();
      logic v;
      v = (q_pc.size() != 0);
      chk("out_valid", {31'd0, out_valid}, {31'd0, v});
      chk("level", {29'd0, level}, q_pc.size());
      chk("out_instr", out_instr, v ? q_instr[0] : NOP_W);
      chk("out_pc", out_pc, v ? q_pc[0] : 32'd0);
      chk("out_fault", {31'd0, out_fault}, {31'd0, v ? q_fault[0] : 1'b0});
   endtask

   // One clock cycle: called just after a falling edge, returns at the next one
   task automatic do_cycle(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                           input logic redir, input logic [31:0] rpc, input logic rdy);
      int  pre_size;
      logic pop;
      logic flt;
      wr_en = wr; wr_addr = addr; instr_in = data;
      redirect = redir; redirect_pc = rpc; out_ready = rdy;
      #1;
      check_outputs();
      pre_size = q_pc.size();
      pop = (pre_size > 0) && rdy;
      if (redir) begin
         model_clear();
         m_pc = rpc;
      end else begin
         if (pop) begin
            void'(q_instr.pop_front());
            void'(q_pc.pop_front());
            void'(q_fault.pop_front());
         end
         if (pre_size < DEPTH || pop) begin
            flt = (m_pc % 4 != 0) || (m_pc >= SIZE * 4);
            q_instr.push_back(flt ? NOP_W : mem_m[(m_pc / 4) % SIZE]);
            q_pc.push_back(m_pc);
            q_fault.push_back(flt);
            m_pc = m_pc + 4;
         end
      end
      if (wr) mem_m[addr / 4] = data;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) do_cycle(1'b0, 10'd0, 32'd0, 1'b0, 32'd0, rdy);
   endtask

   task automatic redir_to(input logic [31:0] rpc, input logic rdy);
      do_cycle(1'b0, 10'd0, 32'd0, 1'b1, rpc, rdy);
   endtask

   // Assert reset for one clock edge, check the reset state, release on a falling edge
   task automatic apply_reset();
      reset_n = 1'b0;
      wr_en = 1'b0; redirect = 1'b0; out_ready = 1'b0;
      #1;
      model_clear();
      m_pc = RST_PC;
      check_outputs();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; instr_in = '0;
      redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      m_pc = RST_PC;
      @(negedge clk);

      // Load the RAM while held in reset
      for (int i = 0; i < SIZE; i++) begin
         logic [31:0] d;
         d = (i < 8) ? 32'h1000_0000 + i : $urandom;
         wr_en = 1'b1; wr_addr = 10'(i * 4); instr_in = d;
         mem_m[i] = d;
         @(negedge clk);
      end
      wr_en = 1'b0;

      // Streaming with ID always ready
      apply_reset();
      idle(8, 1'b1);

      // ID stalled: queue saturates, head holds, then drains in order
      apply_reset();
      idle(10, 1'b0);
      chk("sat_level", {29'd0, level}, DEPTH);
      chk("sat_pc", out_pc, 32'd0);
      idle(8, 1'b1);

      // Redirect with three entries queued
      apply_reset();
      idle(3, 1'b0);
      chk("pre_redir_level", {29'd0, level}, 32'd3);
      redir_to(32'h20, 1'b1);
      chk("post_redir_valid", {31'd0, out_valid}, 32'd0);
      idle(1, 1'b1);
      chk("redir_pc", out_pc, 32'h20);
      chk("redir_instr", out_instr, mem_m[8]);
      idle(4, 1'b1);

      // Misaligned and out-of-range redirects, plus back-to-back redirects
      redir_to(32'h22, 1'b1);
      idle(4, 1'b1);
      redir_to(32'h400, 1'b1);
      idle(4, 1'b1);
      redir_to(32'h3f8, 1'b0);
      redir_to(32'h40, 1'b1);
      idle(4, 1'b1);

      // Write to the word being fetched in the same cycle: old word delivered
      apply_reset();
      idle(3, 1'b1);
      do_cycle(1'b1, 10'd12, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1);
      idle(4, 1'b1);
      redir_to(32'd12, 1'b1);
      idle(3, 1'b1);

      // Asynchronous reset mid-stream with two entries queued
      apply_reset();
      idle(2, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      model_clear();
      m_pc = RST_PC;
      check_outputs();
      @(negedge clk);
      reset_n = 1'b1;
      idle(5, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic        wr;
         logic        rd;
         logic [31:0] rpc;
         int          sel;
         wr  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 15) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 7)       rpc = 32'($urandom_range(0, SIZE - 1) * 4);
         else if (sel < 9)  rpc = 32'($urandom_range(0, SIZE * 4 - 1));
         else               rpc = $urandom;
         do_cycle(wr, 10'($urandom_range(0, 1023)), $urandom, rd, rpc,
                  1'($urandom_range(0, 2) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
